// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: HI/LO op codes and sequencer states.
// Optional macro MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU codes.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator: products, quotient/remainder and (with MDU_MADD_EN)
// multiply-accumulate against the current HI/LO. res_valid marks ops that start a latency run.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_valid
);

  logic signed [63:0] w_a_sx;
  logic signed [63:0] w_b_sx;
  logic        [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic        [31:0] w_a_mag;
  logic        [31:0] w_b_mag;
  logic        [31:0] w_q_mag;
  logic        [31:0] w_r_mag;
  logic        [31:0] w_q_s;
  logic        [31:0] w_r_s;
  logic        [31:0] w_q_u;
  logic        [31:0] w_r_u;
  logic               w_b_zero;

  assign w_a_sx   = {{32{a[31]}}, a};
  assign w_b_sx   = {{32{b[31]}}, b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, a} * {32'd0, b};
  assign w_b_zero = (b == 32'd0);

  // Signed divide on magnitudes; 0x80000000/-1 falls out as lo=0x80000000, hi=0.
  assign w_a_mag = a[31] ? (~a + 32'd1) : a;
  assign w_b_mag = b[31] ? (~b + 32'd1) : b;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_q_s   = (a[31] ^ b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_s   = a[31] ? (~w_r_mag + 32'd1) : w_r_mag;
  assign w_q_u   = a / b;
  assign w_r_u   = a % b;

`ifdef MDU_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = {hi, lo};
`endif

  always_comb begin
    res_hi    = hi;
    res_lo    = lo;
    res_valid = 1'b0;
    case (md_op)
      MD_MULT:  begin {res_hi, res_lo} = w_prod_s; res_valid = 1'b1; end
      MD_MULTU: begin {res_hi, res_lo} = w_prod_u; res_valid = 1'b1; end
      MD_DIV: begin
        res_valid = 1'b1;
        if (!w_b_zero) begin
          res_hi = w_r_s;
          res_lo = w_q_s;
        end
      end
      MD_DIVU: begin
        res_valid = 1'b1;
        if (!w_b_zero) begin
          res_hi = w_r_u;
          res_lo = w_q_u;
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD:  begin {res_hi, res_lo} = w_acc + w_prod_s; res_valid = 1'b1; end
      MD_MADDU: begin {res_hi, res_lo} = w_acc + w_prod_u; res_valid = 1'b1; end
      MD_MSUB:  begin {res_hi, res_lo} = w_acc - w_prod_s; res_valid = 1'b1; end
      MD_MSUBU: begin {res_hi, res_lo} = w_acc - w_prod_u; res_valid = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: IDLE/RUN FSM, latency counter, pending and architectural HI/LO.
// Define MDU_MADD_EN to accept the multiply-accumulate op codes.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output mdu_state_e  o_dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_pend_hi;
  logic [31:0]        r_pend_lo;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  mdu_state_e         w_state_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic [31:0]        w_pend_hi_nx;
  logic [31:0]        w_pend_lo_nx;
  logic [31:0]        w_hi_nx;
  logic [31:0]        w_lo_nx;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_res_valid;

  mdu_arith u_arith (
    .md_op     (md_op),
    .a         (a),
    .b         (b),
    .hi        (r_hi),
    .lo        (r_lo),
    .res_hi    (w_res_hi),
    .res_lo    (w_res_lo),
    .res_valid (w_res_valid)
  );

  // Handshake: start is a one-cycle strobe accepted only in IDLE; busy is high from the cycle
  // after acceptance until HI/LO commit, and the hazard unit keeps start low while busy.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_pend_hi_nx = r_pend_hi;
    w_pend_lo_nx = r_pend_lo;
    w_hi_nx      = r_hi;
    w_lo_nx      = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_res_valid) begin
            w_pend_hi_nx = w_res_hi;
            w_pend_lo_nx = w_res_lo;
            w_cnt_nx     = is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            w_state_nx   = ST_RUN;
          end else if (md_op == MD_MTHI) begin
            w_hi_nx = a;
          end else if (md_op == MD_MTLO) begin
            w_lo_nx = a;
          end
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_hi_nx    = r_pend_hi;
          w_lo_nx    = r_pend_lo;
          w_cnt_nx   = '0;
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_pend_hi <= w_pend_hi_nx;
      r_pend_lo <= w_pend_lo_nx;
      r_hi      <= w_hi_nx;
      r_lo      <= w_lo_nx;
    end
  end

  assign busy        = (r_state == ST_RUN);
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, hand sequences for reset/MT/overlap,
// and randomized ops scored against a 64-bit arithmetic reference model.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  mdu_state_e  dbg_state;

  int tests = 0;
  int fails = 0;
  int viol  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_ctrl #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .md_op       (md_op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .hi          (hi),
    .lo          (lo),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (!reset && start && busy) begin
      viol <= viol + 1;
      $display("[TB] protocol error: start asserted while busy at %0t", $time);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    md_op = MD_NONE;
  endtask

  task automatic count_busy(inout int n);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // reference model: HI/LO as a 64-bit pair, 64-bit host arithmetic
  task automatic model_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          inout logic [31:0] mh, inout logic [31:0] ml, output int lat);
    longint          sx;
    longint          sy;
    longint unsigned ux;
    longint unsigned uy;
    logic [63:0]     acc;
    logic [63:0]     q;
    logic [63:0]     r;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    acc = {mh, ml};
    lat = 0;
    case (op)
      MD_MULT:  begin acc = sx * sy; lat = MULT_LAT; end
      MD_MULTU: begin acc = ux * uy; lat = MULT_LAT; end
      MD_DIV: begin
        lat = DIV_LAT;
        if (y != 0) begin
          q = sx / sy;
          r = sx % sy;
          acc = {r[31:0], q[31:0]};
        end
      end
      MD_DIVU: begin
        lat = DIV_LAT;
        if (y != 0) begin
          q = ux / uy;
          r = ux % uy;
          acc = {r[31:0], q[31:0]};
        end
      end
      MD_MTHI: acc[63:32] = x;
      MD_MTLO: acc[31:0]  = x;
`ifdef MDU_MADD_EN
      MD_MADD:  begin acc = acc + 64'(sx * sy); lat = MULT_LAT; end
      MD_MADDU: begin acc = acc + ux * uy;      lat = MULT_LAT; end
      MD_MSUB:  begin acc = acc - 64'(sx * sy); lat = MULT_LAT; end
      MD_MSUBU: begin acc = acc - ux * uy;      lat = MULT_LAT; end
`endif
      default: ;
    endcase
    {mh, ml} = acc;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    int          e_busy;
  } vec_t;

  vec_t vt[10];

  initial begin
    int n;
    int lat;
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;

    vt[0] = '{"mult_neg",   MD_MULT,  32'hFFFFFFFE, 32'd3,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFA, MULT_LAT};
    vt[1] = '{"multu",      MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h0,  32'h0,  32'h00000002, 32'hFFFFFFFA, MULT_LAT};
    vt[2] = '{"div_neg",    MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
    vt[3] = '{"divu_zero",  MD_DIVU,  32'd7,        32'd0,        32'h11, 32'h22, 32'h00000011, 32'h00000022, DIV_LAT};
    vt[4] = '{"div_ovf",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,  32'h00000000, 32'h80000000, DIV_LAT};
    vt[5] = '{"divu_big",   MD_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0,  32'h0,  32'h0000000F, 32'h0FFFFFFF, DIV_LAT};
    vt[6] = '{"undef_op",   4'hF,     32'h1,        32'h1,        32'h33, 32'h44, 32'h00000033, 32'h00000044, 0};
    vt[7] = '{"none_op",    MD_NONE,  32'h9,        32'h9,        32'h7,  32'h8,  32'h00000007, 32'h00000008, 0};
`ifdef MDU_MADD_EN
    vt[8] = '{"maddu_carry", MD_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, MULT_LAT};
    vt[9] = '{"msub",        MD_MSUB,  32'd2, 32'd3, 32'h0, 32'd10,       32'h00000000, 32'h00000004, MULT_LAT};
`else
    vt[8] = '{"maddu_off",   MD_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0};
    vt[9] = '{"msub_off",    MD_MSUB,  32'd2, 32'd3, 32'h0, 32'd10,       32'h00000000, 32'h0000000A, 0};
`endif

    reset = 1'b1;
    start = 1'b0;
    md_op = MD_NONE;
    a     = '0;
    b     = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;

    // directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op(MD_MTHI, vt[i].pre_hi, 32'd0);
      run_op(MD_MTLO, vt[i].pre_lo, 32'd0);
      chk({vt[i].name, "_preset"}, {hi, lo}, {vt[i].pre_hi, vt[i].pre_lo});
      run_op(vt[i].op, vt[i].x, vt[i].y);
      n = 0;
      count_busy(n);
      chk({vt[i].name, "_busy"}, 64'(n), 64'(vt[i].e_busy));
      chk({vt[i].name, "_hilo"}, {hi, lo}, {vt[i].e_hi, vt[i].e_lo});
    end

    // MTHI then MTLO on back-to-back cycles
    @(negedge clk);
    start = 1'b1;
    md_op = MD_MTHI;
    a     = 32'h1234;
    @(negedge clk);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'd0);
    md_op = MD_MTLO;
    a     = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    md_op = MD_NONE;
    chk("mtlo_lo", 64'(lo), 64'h5678);
    chk("mtlo_hi", 64'(hi), 64'h1234);
    chk("mtlo_busy", 64'(busy), 64'd0);

    // start while busy: second request dropped, first commits on schedule
    run_op(MD_MULT, 32'd3, 32'd5);
    start = 1'b1;
    md_op = MD_MULT;
    a     = 32'd7;
    b     = 32'd7;
    n     = 1;
    @(negedge clk);
    start = 1'b0;
    md_op = MD_NONE;
    count_busy(n);
    chk("ovl_busy", 64'(n), 64'(MULT_LAT));
    chk("ovl_hilo", {hi, lo}, {32'd0, 32'd15});
    chk("ovl_flagged", 64'(viol), 64'd1);

    // async reset in the middle of a run
    run_op(MD_MTHI, 32'h55, 32'd0);
    run_op(MD_MULT, 32'd3, 32'd5);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rstrun_busy", 64'(busy), 64'd0);
    chk("rstrun_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstrun_nocommit", {hi, lo}, 64'd0);
    chk("rstrun_idle", 64'(busy), 64'd0);

    // randomized ops against the reference model
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 11));
      case ($urandom_range(0, 7))
        0:       x = 32'h80000000;
        1:       x = 32'hFFFFFFFF;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'hFFFFFFFF;
        2:       y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      model_op(op, x, y, m_hi, m_lo, lat);
      exp_q.push_back({m_hi, m_lo});
      run_op(op, x, y);
      n = 0;
      count_busy(n);
      chk("rnd_busy", 64'(n), 64'(lat));
      chk("rnd_hilo", {hi, lo}, exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
